matrix_reader: RTL
==================

Name: matrix_reader

Overview:
- Read-side counterpart of the matrix storage register.
- On a start pulse, snapshots a packed DIM x DIM matrix word and streams it out one element per transfer over a valid/ready interface.
- Order is row-major, or column-major when transpose is requested.
- Sits between the matrix memory and the result/output path of the matrix calculator, for example a display or UART formatter.

Parameters:
- ELEM_W, 16, width of one matrix element in bits.
- DIM, 4, matrix dimension. The matrix is DIM x DIM elements, packed word width is DIM*DIM*ELEM_W, giving 256 at defaults.
- IDX_W, 2, width of the row/column index. Must equal clog2(DIM); the integrator sets it consistently.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a readout. Sampled only in IDLE.
- transpose  input  1  sampled with start. 0 = row-major order, 1 = column-major order.
- matrix  input  DIM*DIM*ELEM_W  packed matrix. Element (r,c) sits at bits [(r*DIM+c)*ELEM_W +: ELEM_W]; element (0,0) is at the LSBs.
- out_ready  input  1  downstream accepts the current element.
- out_valid  output  1  current element is valid.
- out_data  output  ELEM_W  element value.
- out_row  output  IDX_W  source row of out_data.
- out_col  output  IDX_W  source column of out_data.
- out_last  output  1  high with out_valid on the final element (k = DIM*DIM-1).
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset:
  - Reset has priority over all other inputs.
  - State = IDLE; shadow register, element counter k and transpose flag are cleared.
  - out_valid, out_last, busy and done = 0.
  - out_data, out_row and out_col = 0.
  - Reset asserted mid-stream abandons the readout immediately. No done pulse is produced.
- State machine (states IDLE, STREAM, DONE):
  - IDLE: on start=1, capture matrix into the shadow register, capture transpose, set k=0, go to STREAM. Otherwise hold, with all outputs at their reset values.
  - STREAM: out_valid=1 and busy=1. A transfer occurs on any cycle with out_valid & out_ready.
    - On a transfer with k < DIM*DIM-1: k increments.
    - On a transfer with k = DIM*DIM-1: go to DONE.
    - Without a transfer: k and all outputs hold stable (standard valid/ready; valid never drops before acceptance).
  - DONE: done=1, busy=1, out_valid=0. Unconditionally return to IDLE next cycle.
- Indexing:
  - transpose=0: out_row = k / DIM, out_col = k % DIM.
  - transpose=1: out_col = k / DIM, out_row = k % DIM.
  - out_data = shadow[(out_row*DIM+out_col)*ELEM_W +: ELEM_W].
  - out_row and out_col always report the source coordinates.
- Outputs in STREAM are functions of registered state (state, k, shadow, flag) only. There is no combinational path from out_ready or start to any output.
- Latency:
  - start sampled high on edge N gives out_valid=1 in the cycle following edge N.
  - With out_ready held at 1, DIM*DIM consecutive transfers occur, followed by done for one cycle, then IDLE.
  - A new start is accepted no earlier than the cycle after done.
- Boundary conditions:
  - start or transpose changes outside IDLE are ignored.
  - Changes on matrix after capture do not affect the stream.
  - start held high continuously produces back-to-back readouts with exactly one IDLE cycle between done and the next capture.
  - k never exceeds DIM*DIM-1; there is no wrap into a second pass.

Test Plan:
- Reset and idle: reset held for 2 cycles, then start=0 for 5 cycles -> all outputs stay 0 and busy=0.
- Row-major stream: element (r,c) = 16'h0100*r + c; start with transpose=0 and out_ready=1.
  - Expected: 16 transfers in order 0000,0001,0002,0003,0100, ... ,0303.
  - out_last only on 0303; done one cycle later; busy then low.
- Transposed stream: same matrix with transpose=1.
  - Expected order: 0000,0100,0200,0300,0001, ... ,0303.
  - out_row/out_col equal the value's (hi byte, lo byte) pair.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_data, out_row, out_col and out_valid stay stable during stall cycles; no element is dropped or duplicated; still exactly 16 transfers.
- Snapshot and ignored start: change matrix to all 16'hFFFF and pulse start during STREAM -> the stream still shows the captured values, and no restart occurs.
- Reset mid-operation: assert reset after the 5th transfer -> outputs are 0 next cycle and no done pulse; a following start streams from element (0,0).

Source files
------------

// File: rtl/matrix_reader.sv
// Streams a snapshot of a packed DIM x DIM matrix one element per valid/ready
// transfer, row-major or column-major, then pulses done for a single cycle.
module matrix_reader #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4,
    parameter int IDX_W  = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      transpose,
    input  logic [DIM*DIM*ELEM_W-1:0] matrix,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [ELEM_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_row,
    output logic [IDX_W-1:0]          out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int N  = DIM * DIM;
    localparam int KW = 2 * IDX_W;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                       state;
    logic [N-1:0][ELEM_W-1:0]     shadow;
    logic [KW-1:0]                k;
    logic                         flag;

    logic [IDX_W-1:0] k_hi, k_lo, row, col;
    logic [KW-1:0]    idx;
    logic             streaming;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            k      <= '0;
            flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shadow <= matrix;
                    flag   <= transpose;
                    k      <= '0;
                    state  <= STREAM;
                end
                STREAM: if (out_ready) begin
                    // k stops at the final index; the exit goes through DONE
                    if (k == KW'(N-1)) state <= DONE;
                    else               k     <= k + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Everything below depends only on registered state, never on out_ready/start
    assign k_hi      = IDX_W'(k / KW'(DIM));
    assign k_lo      = IDX_W'(k % KW'(DIM));
    assign row       = flag ? k_lo : k_hi;
    assign col       = flag ? k_hi : k_lo;
    assign idx       = KW'(row) * KW'(DIM) + KW'(col);
    assign streaming = (state == STREAM);

    assign out_valid = streaming;
    assign out_data  = streaming ? shadow[idx] : '0;
    assign out_row   = streaming ? row : '0;
    assign out_col   = streaming ? col : '0;
    assign out_last  = streaming && (k == KW'(N-1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
